rans_enc_ctrl: RTL and testbench

Sequencer in front of the rANS encoder core. Per block it does three things:
- Loads the 2^SYMBOL_WIDTH-entry frequency table into the encoder, computing cumulative frequencies on the fly, and checks that the total equals 2^RESOLUTION.
- Forwards the symbol stream to the encoder under valid/ready, rejecting symbols that have zero frequency.
- Issues restart after the last symbol.
It sits between the DMA-side streams and the encoder's input port.

---
 rtl/rans_pkg.sv | 27 ++
 rtl/rans_enc_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rans_enc_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rans_pkg.sv
// Shared types and size helpers for the rANS encoder sequencer.
package rans_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_ENCODE,
      ST_FLUSH,
      ST_DONE,
      ST_ERR
   } rans_ctrl_state_t;

   function automatic int unsigned num_symbols(input int unsigned symbol_width);
      return 32'd1 << symbol_width;
   endfunction

   function automatic int unsigned prob_total(input int unsigned resolution);
      return 32'd1 << resolution;
   endfunction

   localparam int unsigned DEF_SYMBOL_WIDTH = 8;
   localparam int unsigned DEF_RESOLUTION   = 10;
   localparam int unsigned NUM_SYMBOLS      = num_symbols(DEF_SYMBOL_WIDTH);
   localparam int unsigned PROB_TOTAL       = prob_total(DEF_RESOLUTION);

endpackage

// File: rtl/rans_enc_ctrl.sv
// Block sequencer for the rANS encoder: frequency-table load with prefix sums,
// total check, zero-frequency symbol filtering and end-of-block restart.
module rans_enc_ctrl
   import rans_pkg::*;
#(
   parameter int RESOLUTION   = 10,
   parameter int SYMBOL_WIDTH = 8,
   parameter int COUNT_WIDTH  = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    ftab_valid_i,
   output logic                    ftab_ready_o,
   input  logic [RESOLUTION-1:0]   ftab_freq_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   input  logic [SYMBOL_WIDTH-1:0] s_symb_i,
   input  logic                    s_last_i,
   output logic                    enc_freq_wr_o,
   output logic [SYMBOL_WIDTH-1:0] enc_freq_addr_o,
   output logic [RESOLUTION-1:0]   enc_freq_o,
   output logic [RESOLUTION-1:0]   enc_cum_freq_o,
   output logic                    enc_valid_o,
   output logic [SYMBOL_WIDTH-1:0] enc_symb_o,
   input  logic                    enc_ready_i,
   output logic                    enc_restart_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   output logic [COUNT_WIDTH-1:0]  sym_cnt_o
);

   localparam int unsigned NSYM  = num_symbols(SYMBOL_WIDTH);
   localparam int          SUM_W = RESOLUTION + 1;
   localparam logic [SUM_W-1:0]        TOTAL     = SUM_W'(prob_total(RESOLUTION));
   localparam logic [SYMBOL_WIDTH-1:0] LAST_ADDR = '1;

   rans_ctrl_state_t          state_q, state_d;
   logic [SYMBOL_WIDTH-1:0]   addr_q, addr_d;
   logic [SUM_W-1:0]          sum_q, sum_d;
   logic [NSYM-1:0]           nz_q, nz_d;
   logic [COUNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic                      wr_q, wr_d;
   logic [SYMBOL_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [RESOLUTION-1:0]     wr_freq_q, wr_freq_d;
   logic [RESOLUTION-1:0]     wr_cum_q, wr_cum_d;
   logic                      restart_q, restart_d;
   logic                      sym_nz;

   // Running sum sticks at all-ones so an oversized table can never wrap back to the total.
   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [RESOLUTION-1:0] b);
      logic [SUM_W:0] t;
      t = {1'b0, a} + (SUM_W+1)'(b);
      return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
   endfunction

   assign sym_nz = nz_q[s_symb_i];

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      sum_d        = sum_q;
      nz_d         = nz_q;
      cnt_d        = cnt_q;
      wr_d         = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_freq_d    = wr_freq_q;
      wr_cum_d     = wr_cum_q;
      restart_d    = 1'b0;
      ftab_ready_o = 1'b0;
      s_ready_o    = 1'b0;
      enc_valid_o  = 1'b0;
      enc_symb_o   = '0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      err_o        = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_ERR: begin
            err_o = (state_q == ST_ERR);
            if (start_i) begin
               state_d = ST_LOAD;
               addr_d  = '0;
               sum_d   = '0;
               nz_d    = '0;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            busy_o       = 1'b1;
            ftab_ready_o = 1'b1;
            if (ftab_valid_i) begin
               wr_d         = 1'b1;
               wr_addr_d    = addr_q;
               wr_freq_d    = ftab_freq_i;
               wr_cum_d     = sum_q[RESOLUTION-1:0];
               sum_d        = sat_add(sum_q, ftab_freq_i);
               nz_d[addr_q] = |ftab_freq_i;
               addr_d       = addr_q + 1'b1;
               if (addr_q == LAST_ADDR) state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            busy_o  = 1'b1;
            state_d = (sum_q == TOTAL) ? ST_ENCODE : ST_ERR;
         end
         ST_ENCODE: begin
            busy_o      = 1'b1;
            enc_symb_o  = s_symb_i;
            enc_valid_o = s_valid_i & sym_nz;
            s_ready_o   = enc_ready_i & sym_nz;
            if (s_valid_i && !sym_nz) begin
               state_d   = ST_ERR;
               restart_d = 1'b1;
            end else if (s_valid_i && s_ready_o) begin
               cnt_d = cnt_q + 1'b1;
               if (s_last_i) begin
                  state_d   = ST_FLUSH;
                  restart_d = 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            busy_o = 1'b1;
            // First FLUSH cycle carries the restart pulse; completion waits past it.
            if (!restart_q && enc_ready_i) state_d = ST_DONE;
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         sum_q     <= '0;
         nz_q      <= '0;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         wr_addr_q <= '0;
         wr_freq_q <= '0;
         wr_cum_q  <= '0;
         restart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         sum_q     <= sum_d;
         nz_q      <= nz_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         wr_addr_q <= wr_addr_d;
         wr_freq_q <= wr_freq_d;
         wr_cum_q  <= wr_cum_d;
         restart_q <= restart_d;
      end
   end

   assign enc_freq_wr_o   = wr_q;
   assign enc_freq_addr_o = wr_addr_q;
   assign enc_freq_o      = wr_freq_q;
   assign enc_cum_freq_o  = wr_cum_q;
   assign enc_restart_o   = restart_q;
   assign sym_cnt_o       = cnt_q;

endmodule

// File: tb/tb_rans_enc_ctrl.sv
// Randomized self-checking bench for rans_enc_ctrl against a table/stream reference model.
module tb_rans_enc_ctrl;

   localparam int R  = 10;
   localparam int SW = 8;
   localparam int CW = 32;
   localparam int NS = 256;
   localparam int TOT = 1024;

   logic          clk = 1'b0;
   logic          rst, start, ftab_valid, s_valid, s_last, enc_ready;
   logic [R-1:0]  ftab_freq;
   logic [SW-1:0] s_symb;
   logic          ftab_ready_o, s_ready_o, enc_freq_wr_o, enc_valid_o, enc_restart_o;
   logic          busy_o, done_o, err_o;
   logic [SW-1:0] enc_freq_addr_o, enc_symb_o;
   logic [R-1:0]  enc_freq_o, enc_cum_freq_o;
   logic [CW-1:0] sym_cnt_o;

   rans_enc_ctrl #(.RESOLUTION(R), .SYMBOL_WIDTH(SW), .COUNT_WIDTH(CW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .ftab_valid_i(ftab_valid), .ftab_ready_o(ftab_ready_o), .ftab_freq_i(ftab_freq),
      .s_valid_i(s_valid), .s_ready_o(s_ready_o), .s_symb_i(s_symb), .s_last_i(s_last),
      .enc_freq_wr_o(enc_freq_wr_o), .enc_freq_addr_o(enc_freq_addr_o),
      .enc_freq_o(enc_freq_o), .enc_cum_freq_o(enc_cum_freq_o),
      .enc_valid_o(enc_valid_o), .enc_symb_o(enc_symb_o), .enc_ready_i(enc_ready),
      .enc_restart_o(enc_restart_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .sym_cnt_o(sym_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; int freq; int cum; } wr_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned tab[NS];
   int          stim[$];
   wr_t         wr_log[$];
   int          fwd_log[$];
   int          n_restart = 0;
   int          n_done    = 0;

   always @(negedge clk) begin
      if (enc_freq_wr_o)
         wr_log.push_back('{int'(enc_freq_addr_o), int'(enc_freq_o), int'(enc_cum_freq_o)});
      if (enc_valid_o && enc_ready) fwd_log.push_back(int'(enc_symb_o));
      if (enc_restart_o) n_restart++;
      if (done_o) n_done++;
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      wr_log.delete();
      fwd_log.delete();
      n_restart = 0;
      n_done    = 0;
   endtask

   task automatic reset_dut();
      rst = 1'b1; start = 1'b0; ftab_valid = 1'b0; ftab_freq = '0;
      s_valid = 1'b0; s_last = 1'b0; s_symb = '0; enc_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      clear_mon();
   endtask

   task automatic start_blk();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_table(input int stop);
      bit hs;
      int guard;
      for (int i = 0; i < stop; i++) begin
         ftab_valid = 1'b0;
         if ($urandom_range(0, 3) == 0) tick();
         ftab_valid = 1'b1;
         ftab_freq  = tab[i][R-1:0];
         hs = 1'b0;
         guard = 0;
         while (!hs && guard < 20) begin
            @(negedge clk);
            hs = ftab_ready_o;
            @(posedge clk);
            #1;
            guard++;
         end
         if (!hs) begin
            chk("ftab_hs_timeout", 0, 1);
            break;
         end
      end
      ftab_valid = 1'b0;
   endtask

   // Reference: every entry written once, in address order, with the exclusive prefix sum.
   task automatic verify_table(input string tag);
      int bad = 0;
      int run = 0;
      int exp_cum;
      chk({tag, "_nwr"}, wr_log.size(), NS);
      for (int i = 0; i < NS && i < wr_log.size(); i++) begin
         exp_cum = ((run > 2047) ? 2047 : run) % TOT;
         if (wr_log[i].addr != i || wr_log[i].freq != int'(tab[i]) || wr_log[i].cum != exp_cum)
            bad++;
         run += int'(tab[i]);
      end
      chk({tag, "_wr_bad"}, bad, 0);
   endtask

   task automatic run_stream(input bit poke_start);
      bit hs, zero;
      int guard;
      for (int i = 0; i < stim.size(); i++) begin
         s_valid = 1'b0;
         repeat ($urandom_range(0, 1)) tick();
         if (poke_start && i == 1) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("start_ignored_cnt", sym_cnt_o, 1);
            chk("start_ignored_busy", busy_o, 1);
         end
         s_valid = 1'b1;
         s_symb  = stim[i][SW-1:0];
         s_last  = (i == stim.size() - 1);
         zero    = (tab[stim[i]] == 0);
         hs = 1'b0;
         guard = 0;
         while (!hs && guard < 60) begin
            enc_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            hs = s_ready_o;
            @(posedge clk);
            #1;
            guard++;
            if (zero) break;
         end
         if (zero) begin
            chk("zero_sym_rejected", hs, 0);
            break;
         end
         if (!hs) chk("sym_hs_timeout", 0, 1);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic finish_block(output bit got_done, output bit got_err);
      got_done = 1'b0;
      got_err  = 1'b0;
      for (int g = 0; g < 100; g++) begin
         enc_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (done_o) got_done = 1'b1;
         if (err_o)  got_err  = 1'b1;
         @(posedge clk);
         #1;
         if (got_done || got_err) break;
      end
      enc_ready = 1'b0;
      tick();
   endtask

   task automatic run_block(input bit poke_start);
      int  total = 0;
      int  exp_fwd[$];
      bit  exp_err = 1'b0;
      bit  got_done, got_err;
      int  bad = 0;
      reset_dut();
      start_blk();
      load_table(NS);
      tick();
      tick();
      verify_table("load");
      foreach (tab[i]) total += int'(tab[i]);
      chk("check_err", err_o, (total != TOT));
      chk("check_busy", busy_o, (total == TOT));
      if (total != TOT) begin
         s_valid = 1'b1; s_symb = '0; enc_ready = 1'b1;
         tick();
         chk("err_s_ready", s_ready_o, 0);
         chk("err_enc_valid", enc_valid_o, 0);
         s_valid = 1'b0; enc_ready = 1'b0;
         chk("check_no_restart", n_restart, 0);
         got_err = 1'b1;
      end else begin
         foreach (stim[i]) begin
            if (tab[stim[i]] == 0) begin
               exp_err = 1'b1;
               break;
            end
            exp_fwd.push_back(stim[i]);
         end
         run_stream(poke_start);
         finish_block(got_done, got_err);
         chk("fwd_count", fwd_log.size(), exp_fwd.size());
         for (int i = 0; i < exp_fwd.size() && i < fwd_log.size(); i++)
            if (fwd_log[i] != exp_fwd[i]) bad++;
         chk("fwd_order", bad, 0);
         chk("sym_cnt", sym_cnt_o, exp_fwd.size());
         chk("restart_pulses", n_restart, 1);
         chk("done_seen", got_done, !exp_err);
         chk("err_seen", got_err, exp_err);
         chk("done_pulses", n_done, exp_err ? 0 : 1);
         if (!exp_err) chk("idle_after_done", busy_o, 0);
      end
      if (got_err) begin
         repeat (3) tick();
         chk("err_sticky", err_o, 1);
         start_blk();
         chk("err_cleared", err_o, 0);
         chk("cnt_cleared", sym_cnt_o, 0);
         chk("restart_busy", busy_o, 1);
      end
   endtask

   task automatic gen_random(input bit bad);
      int nzl[$];
      int k, idx, rem, j, add, room, z, n;
      k = $urandom_range(2, 6);
      foreach (tab[i]) tab[i] = 0;
      for (int m = 0; m < k; m++) begin
         do idx = $urandom_range(0, NS - 1); while (tab[idx] != 0);
         tab[idx] = 1;
         nzl.push_back(idx);
      end
      rem = TOT - k;
      while (rem > 0) begin
         j    = $urandom_range(0, k - 1);
         add  = $urandom_range(1, rem);
         room = 1023 - int'(tab[nzl[j]]);
         if (add > room) add = room;
         tab[nzl[j]] += add;
         rem -= add;
      end
      if (bad) begin
         if (tab[nzl[0]] < 1023) tab[nzl[0]]++;
         else tab[nzl[0]]--;
      end
      stim.delete();
      n = $urandom_range(1, 8);
      for (int m = 0; m < n; m++) stim.push_back(nzl[$urandom_range(0, k - 1)]);
      if ($urandom_range(0, 2) == 0) begin
         do z = $urandom_range(0, NS - 1); while (tab[z] != 0);
         stim.insert($urandom_range(0, n - 1), z);
      end
   endtask

   initial begin
      reset_dut();
      chk("rst_ftab_ready", ftab_ready_o, 0);
      chk("rst_s_ready", s_ready_o, 0);
      chk("rst_enc_valid", enc_valid_o, 0);
      chk("rst_wr", enc_freq_wr_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_restart", enc_restart_o, 0);
      chk("rst_cnt", sym_cnt_o, 0);

      // Uniform table and a three-symbol block
      foreach (tab[i]) tab[i] = 4;
      stim = '{32'h10, 32'h20, 32'h30};
      run_block(1'b0);

      // Total one too large
      foreach (tab[i]) tab[i] = 4;
      tab[NS-1] = 5;
      stim.delete();
      run_block(1'b0);

      // Two-symbol table, zero-frequency symbol in stream
      foreach (tab[i]) tab[i] = 0;
      tab[0] = 512;
      tab[1] = 512;
      stim = '{32'h00, 32'h41, 32'h01};
      run_block(1'b0);

      // Reset in the middle of the table load
      foreach (tab[i]) tab[i] = 4;
      reset_dut();
      start_blk();
      load_table(100);
      rst = 1'b1;
      tick();
      chk("midrst_ftab_ready", ftab_ready_o, 0);
      chk("midrst_wr", enc_freq_wr_o, 0);
      chk("midrst_addr", enc_freq_addr_o, 0);
      chk("midrst_busy", busy_o, 0);
      rst = 1'b0;
      tick();
      chk("midrst_no_restart", n_restart, 0);
      clear_mon();
      start_blk();
      load_table(NS);
      tick();
      tick();
      verify_table("reload");
      if (wr_log.size() == NS) begin
         chk("reload_first_cum", wr_log[0].cum, 0);
         chk("reload_last_cum", wr_log[NS-1].cum, 1020);
      end
      chk("reload_busy", busy_o, 1);

      // start_i during ENCODE is ignored
      foreach (tab[i]) tab[i] = 4;
      stim = '{32'h05, 32'h06, 32'hfe, 32'h07};
      run_block(1'b1);

      for (int it = 0; it < 8; it++) begin
         gen_random(it % 4 == 3);
         run_block(1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
